// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding, default widths and register-zero constant for the hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; ports clk, rst_n (async low), inc, clr (sync, wins over inc), q
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush/dmem-wait sequencer; hazard inputs in, stage enables/flushes/pc_src/dmem_req and saturating stall/flush counters out
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             clr_counters,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  state_t state, state_nx;
  logic hold, go, taken, loaduse, lu_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_comb begin
    taken = mem_branch & mem_zero;
    loaduse = ex_memread & (ex_rt != REG_W'(REG_ZERO)) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    hold = (state == MEM_WAIT) ? ~dmem_ready : mem_access & ~dmem_ready;
    state_nx = hold ? MEM_WAIT : RUN;
    go = rst_n & ~hold;
    dmem_req = rst_n & ((state == MEM_WAIT) | mem_access);
    pc_src = go & taken;
    lu_stall = go & ~taken & loaduse;
    pc_en = go & ~lu_stall;
    ifid_en = go & ~lu_stall;
    idex_en = go;
    exmem_en = go;
    memwb_en = go;
    ifid_flush = pc_src;
    idex_flush = pc_src | lu_stall;
    exmem_flush = pc_src;
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .inc(rst_n & ~pc_en), .clr(clr_counters), .q(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst_n(rst_n), .inc(pc_src), .clr(clr_counters), .q(flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a spec-level reference model for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic ex_memread = 0, mem_branch = 0, mem_zero = 0, mem_access = 0, dmem_ready = 0, clr_counters = 0;
  logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, pc_src;
  logic [15:0] stall_count, flush_count;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .clr_counters(clr_counters), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_src(pc_src), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state: an access is outstanding, plus the two event tallies
  bit m_waiting = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit mr,
                       input logic [4:0] xr, input bit br, input bit z, input bit acc,
                       input bit rdy, input bit clr);
    exp_t e;
    bit frozen, tk, lu, req;
    bit pe, fe, de, ee, we, ff, df, xf, ps;
    @(posedge clk);
    #1;
    rst_n = r; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = xr;
    mem_branch = br; mem_zero = z; mem_access = acc; dmem_ready = rdy; clr_counters = clr;
    if (!r) begin
      m_waiting = 0; m_stalls = 0; m_flushes = 0;
    end
    frozen = m_waiting ? !rdy : (acc && !rdy);
    req = m_waiting || acc;
    tk = br && z;
    lu = mr && (xr != 0) && (xr == rs || xr == rt);
    {pe, fe, de, ee, we, ff, df, xf, ps} = '0;
    if (!r) req = 0;
    else if (frozen) ;
    else if (tk) {pe, fe, de, ee, we, ff, df, xf, ps} = 9'h1FF;
    else if (lu) begin
      de = 1; ee = 1; we = 1; df = 1;
    end
    else {pe, fe, de, ee, we} = 5'h1F;
    e.ctl = {req, pe, fe, de, ee, we, ff, df, xf, ps};
    e.sc = 16'(m_stalls);
    e.fc = 16'(m_flushes);
    q.push_back(e);
    if (r) begin
      if (clr) m_stalls = 0;
      else if (!pe && m_stalls < 65535) m_stalls++;
      if (clr) m_flushes = 0;
      else if (ps && m_flushes < 65535) m_flushes++;
      m_waiting = frozen;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = q.pop_front();
      act = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, pc_src};
      vectors++;
      if (act !== e.ctl || stall_count !== e.sc || flush_count !== e.fc) begin
        miscompares++;
        if (miscompares <= 40)
          $display("FAIL vec%0d ctl got %b want %b, stall_count got %0d want %0d, flush_count got %0d want %0d",
                   vectors, act, e.ctl, stall_count, e.sc, flush_count, e.fc);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 8, 3, 1, 8, 0, 0, 0, 0, 0);
    drive(1, 8, 3, 0, 8, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 4, 9, 1, 9, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 0, 0, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 1, 0, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 1, 0, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(1, 8, 0, 1, 8, 0, 0, 0, 0, 0);
    drive(1, 8, 0, 1, 8, 0, 0, 0, 0, 1);
    drive(1, 8, 0, 1, 8, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. It drives write-enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, taken-branch flushes (branch resolved in MEM from the EX/MEM branch bit and zero flag) and data-memory wait handshakes. It also keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, performance counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
ex_memread  in  1  ID/EX instruction is a load
ex_rt  in  REG_W  destination rt of ID/EX instruction
mem_branch  in  1  EX/MEM M-control branch bit
mem_zero  in  1  EX/MEM ALU zero flag
mem_access  in  1  EX/MEM instruction is load or store
dmem_ready  in  1  data memory completion
clr_counters  in  1  synchronous counter clear
dmem_req  out  1  data memory request
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write-enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (all control zero) on next edge
pc_src  out  1  1 = PC loads EX/MEM branch target
stall_count  out  CNT_W  cycles with pc_en=0
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- FSM states:
  - RUN: default.
  - MEM_WAIT: data access outstanding.
- Reset behaviour:
  - State returns to RUN; counters clear to 0.
  - While rst_n=0, all enables, flushes, pc_src and dmem_req are driven 0.
- Control outputs are combinational from state and inputs. No added latency. Decisions take effect at the next clk edge.
- Definitions:
  - freeze = mem_access & ~dmem_ready.
  - taken = mem_branch & mem_zero.
  - loaduse = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- RUN state:
  - dmem_req = mem_access.
  - If freeze: all five enables = 0, no flushes, pc_src = 0, and the next state is MEM_WAIT.
  - If mem_access & dmem_ready: the access completes in a single cycle and the state stays RUN.
- MEM_WAIT state:
  - dmem_req held 1; all enables 0; flushes 0; pc_src 0.
  - On dmem_ready=1: that cycle behaves as RUN with freeze=0 (normal advance, branch/load-use evaluated). Next state is RUN.
  - dmem_ready must not be acted on before dmem_req is high.
- Priority when not frozen: taken > loaduse > normal.
- taken:
  - pc_src=1; all enables 1.
  - ifid_flush, idex_flush and exmem_flush all = 1 (three younger instructions squashed).
  - flush_count increments.
  - loaduse is ignored, because the ID instruction is squashed.
- loaduse (not taken):
  - pc_en=0, ifid_en=0, idex_flush=1.
  - exmem_en=1, memwb_en=1, idex_en=1.
  - Stall lasts one cycle; the condition clears naturally once the bubble is in EX.
- Normal: all enables 1, flushes 0, pc_src 0.
- stall_count increments on every cycle with rst_n=1 and pc_en=0 (freeze, MEM_WAIT or loaduse).
- Counter rules:
  - Both counters saturate at all-ones.
  - clr_counters has priority over increment in the same cycle.
- rst_n assertion in MEM_WAIT drops dmem_req immediately (asynchronously). After release the state is RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1).
  - REG_W and CNT_W defaults.
  - Register number zero constant.
- One sub-module, sat_counter (width parameter; inc, clr; async active-low reset), instantiated twice for stall_count and flush_count.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_count 0->1; no change when ex_rt=0.
- Branch taken: mem_branch=1, mem_zero=1 -> pc_src=1, three flushes=1, flush_count 0->1. With mem_zero=0 -> pc_src=0, no flush.
- Memory wait: mem_access=1, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, enables 0 for 3 cycles, all 1 on the ready cycle, state back to RUN, stall_count +3.
- Simultaneous taken + loaduse -> branch flush only (pc_en=1, idex_flush=1), stall_count unchanged. Taken during freeze -> pc_src=0 until dmem_ready.
- Reset mid-MEM_WAIT: drop rst_n asynchronously -> dmem_req and enables 0 immediately, counters 0. After release with mem_access=0 -> RUN, all enables 1.
- Saturation: preload stall_count to 0xFFFE via repeated stalls, two more stall cycles -> holds 0xFFFF. clr_counters with concurrent stall -> 0.
